// File: rtl/battle_pkg.sv
// Shared types and constants for the battle turn sequencer.
// Holds the FSM state encoding, player indices and datapath widths.
package battle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    APPLY  = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int HP_W_DEFAULT = 4;
  localparam int RND_W        = 4;

  // One-hot grant vector for a player index.
  function automatic logic [1:0] onehot2(input logic idx);
    return (idx == P1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/battle_rr_arb2.sv
// Two-requester round-robin arbiter; ptr picks the winner on a tie.
// Purely combinational, the pointer itself lives in the parent.
module rr_arb2
  import battle_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = onehot2(ptr);
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Turn sequencer: arbitrates attacks, samples the shared RNG, applies damage.
// Optional critical hits are enabled by defining BATTLE_CRIT_EN.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int HP_W       = HP_W_DEFAULT,
  parameter int HP_INIT    = 9,
  parameter int HIT_THRESH = 7,
  parameter int DMG        = 1,
  parameter int SETTLE_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic             restart,
  input  logic [RND_W-1:0] rnd_in,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             crit,
  output logic [HP_W-1:0]  hp0,
  output logic [HP_W-1:0]  hp1,
  output logic             game_over,
  output logic             winner
);

  localparam int CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CNT_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  localparam logic [HP_W-1:0]  HP_RELOAD = HP_W'(HP_INIT);
  localparam logic [RND_W-1:0] THRESH    = RND_W'(HIT_THRESH);
  localparam logic [HP_W+1:0]  DMG_NORM  = (HP_W+2)'(DMG);
  localparam logic [HP_W+1:0]  DMG_CRIT  = (HP_W+2)'(2 * DMG);

  state_t            state_reg, state_next;
  logic              ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              attacker_reg;
  logic [RND_W-1:0]  rnd_reg;
  logic [HP_W-1:0]   hp0_reg, hp1_reg;
  logic              game_over_reg;
  logic              winner_reg;

  logic              arb_en;
  logic [1:0]        arb_gnt;
  logic              granted;
  logic              grant_idx;
  logic              defender;
  logic              is_hit;
  logic              is_crit;
  logic [HP_W+1:0]   dmg;
  logic [HP_W+1:0]   def_hp_ext;
  logic [HP_W+1:0]   hp_after;
  logic [HP_W-1:0]   hp_new;
  logic              kill;
  logic              apply_go;

  // Arbitration is only live in IDLE and is masked by restart.
  assign arb_en = (state_reg == IDLE) && !restart;

  rr_arb2 u_arb (
    .req (req),
    .ptr (ptr_reg),
    .en  (arb_en),
    .gnt (arb_gnt)
  );

  assign granted   = |arb_gnt;
  assign grant_idx = arb_gnt[1];

`ifdef BATTLE_CRIT_EN
  assign is_crit = (rnd_reg == {RND_W{1'b1}});
`else
  assign is_crit = 1'b0;
`endif

  assign defender   = ~attacker_reg;
  assign is_hit     = (rnd_reg > THRESH) || is_crit;
  assign dmg        = is_crit ? DMG_CRIT : DMG_NORM;
  assign def_hp_ext = {2'b00, (defender == P1) ? hp1_reg : hp0_reg};

  // Saturating subtract in a widened domain so HP can never wrap.
  always_comb begin
    hp_after = def_hp_ext;
    if (is_hit) begin
      hp_after = (def_hp_ext > dmg) ? (def_hp_ext - dmg) : '0;
    end
  end

  assign hp_new   = hp_after[HP_W-1:0];
  assign kill     = is_hit && (hp_after == '0);
  assign apply_go = (state_reg == APPLY) && !restart;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (restart) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (granted) begin
            state_next = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == CNT_W'(CNT_LAST)) begin
            state_next = SAMPLE;
          end
        end
        SAMPLE:  state_next = APPLY;
        APPLY:   state_next = kill ? OVER : IDLE;
        OVER:    state_next = OVER;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    gnt  = arb_gnt;
    busy = (state_reg == SETTLE) || (state_reg == SAMPLE) || (state_reg == APPLY);
    done = apply_go;
    hit  = apply_go && is_hit;
    crit = apply_go && is_crit;
  end

  // Turn datapath: pointer, settle counter, sampled RNG, HP and game-over state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg       <= P0;
      cnt_reg       <= '0;
      attacker_reg  <= P0;
      rnd_reg       <= '0;
      hp0_reg       <= HP_RELOAD;
      hp1_reg       <= HP_RELOAD;
      game_over_reg <= 1'b0;
      winner_reg    <= P0;
    end else if (restart) begin
      ptr_reg       <= P0;
      cnt_reg       <= '0;
      attacker_reg  <= P0;
      hp0_reg       <= HP_RELOAD;
      hp1_reg       <= HP_RELOAD;
      game_over_reg <= 1'b0;
      winner_reg    <= P0;
    end else begin
      if (granted) begin
        attacker_reg <= grant_idx;
        cnt_reg      <= '0;
      end
      if (state_reg == SETTLE) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (state_reg == SAMPLE) begin
        rnd_reg <= rnd_in;
      end
      if (state_reg == APPLY) begin
        if (defender == P1) begin
          hp1_reg <= hp_new;
        end else begin
          hp0_reg <= hp_new;
        end
        ptr_reg <= defender;
        if (kill) begin
          game_over_reg <= 1'b1;
          winner_reg    <= attacker_reg;
        end
      end
    end
  end

  assign hp0       = hp0_reg;
  assign hp1       = hp1_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Self-checking bench for battle_turn_ctrl: directed and random turns against a
// rule-level model, plus a second instance with SETTLE_CYC=0, DMG=3, HP_INIT=4.
module tb_battle_turn_ctrl;

  localparam int HP_INIT    = 9;
  localparam int HIT_THRESH = 7;
  localparam int DMG        = 1;
  localparam int SETTLE_CYC = 3;

`ifdef BATTLE_CRIT_EN
  localparam bit CRIT_EN = 1'b1;
`else
  localparam bit CRIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic       restart = 1'b0;
  logic [3:0] rnd_in = 4'h0;
  logic [1:0] gnt;
  logic       busy, done, hit, crit, game_over, winner;
  logic [3:0] hp0, hp1;

  logic [1:0] req2 = 2'b00;
  logic       restart2 = 1'b0;
  logic [3:0] rnd2 = 4'h0;
  logic [1:0] gnt2;
  logic       busy2, done2, hit2, crit2, game_over2, winner2;
  logic [3:0] hp0_2, hp1_2;

  always #5 clk = ~clk;

  battle_turn_ctrl #(
    .HP_W(4), .HP_INIT(HP_INIT), .HIT_THRESH(HIT_THRESH), .DMG(DMG), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .restart(restart), .rnd_in(rnd_in),
    .gnt(gnt), .busy(busy), .done(done), .hit(hit), .crit(crit),
    .hp0(hp0), .hp1(hp1), .game_over(game_over), .winner(winner)
  );

  battle_turn_ctrl #(
    .HP_W(4), .HP_INIT(4), .HIT_THRESH(7), .DMG(3), .SETTLE_CYC(0)
  ) dut2 (
    .clk(clk), .reset(reset), .req(req2), .restart(restart2), .rnd_in(rnd2),
    .gnt(gnt2), .busy(busy2), .done(done2), .hit(hit2), .crit(crit2),
    .hp0(hp0_2), .hp1(hp1_2), .game_over(game_over2), .winner(winner2)
  );

  int checks = 0;
  int errors = 0;

  // Rule-level model of the game
  int m_hp [2];
  int m_ptr;
  bit m_over;
  int m_winner;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hp[0] = HP_INIT;
    m_hp[1] = HP_INIT;
    m_ptr = 0;
    m_over = 1'b0;
    m_winner = 0;
  endtask

  function automatic int exp_grant(input logic [1:0] r);
    if (m_over || r == 2'b00) return -1;
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return m_ptr;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_hp0"}, hp0, m_hp[0]);
    check({tag, "_hp1"}, hp1, m_hp[1]);
    check({tag, "_over"}, game_over, m_over);
    check({tag, "_winner"}, winner, m_winner);
  endtask

  // One turn on the main instance, starting in an IDLE cycle just after a rising edge.
  task automatic turn(input logic [1:0] r, input logic [3:0] v, input bit hold);
    int g, k, dmg, d;
    bit crit_e, hit_e;
    req = r;
    rnd_in = v;
    g = exp_grant(r);
    @(negedge clk);
    check("gnt", gnt, (g < 0) ? 0 : (1 << g));
    check("busy_idle", busy, 0);
    @(posedge clk); #1;
    if (!hold) req = 2'b00;
    if (g < 0) begin
      $display("turn req=%b rnd=%h no grant hp=%0d/%0d over=%0d", r, v, hp0, hp1, game_over);
      check_state("nogrant");
      return;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check("busy_turn", busy, 1);
    end while (!done && k < 20);
    check("latency", k, SETTLE_CYC + 2);
    crit_e = CRIT_EN && (v == 4'hF);
    hit_e = (v > HIT_THRESH);
    dmg = crit_e ? 2 * DMG : DMG;
    check("hit", hit, hit_e);
    check("crit", crit, crit_e);
    d = 1 - g;
    if (hit_e) begin
      m_hp[d] = (m_hp[d] > dmg) ? m_hp[d] - dmg : 0;
      if (m_hp[d] == 0) begin
        m_over = 1'b1;
        m_winner = g;
      end
    end
    m_ptr = d;
    @(posedge clk); #1;
    $display("turn req=%b rnd=%h att=%0d hit=%0d crit=%0d hp=%0d/%0d over=%0d",
             r, v, g, hit, crit, hp0, hp1, game_over);
    check_state("after_turn");
    check("busy_after", busy, 0);
    check("done_after", done, 0);
  endtask

  task automatic do_restart(input logic [1:0] r);
    req = r;
    restart = 1'b1;
    @(negedge clk);
    check("gnt_restart", gnt, 0);
    check("done_restart", done, 0);
    @(posedge clk); #1;
    restart = 1'b0;
    req = 2'b00;
    model_reset();
    $display("restart req=%b hp=%0d/%0d over=%0d", r, hp0, hp1, game_over);
    check_state("restart");
    check("busy_restart", busy, 0);
  endtask

  task automatic t2_turn(input logic [1:0] r, input logic [1:0] exp_g);
    int k;
    req2 = r;
    rnd2 = 4'hA;
    @(negedge clk);
    check("gnt2", gnt2, exp_g);
    @(posedge clk); #1;
    req2 = 2'b00;
    if (exp_g == 2'b00) return;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done2 && k < 10);
    check("latency2", k, 2);
    check("hit2", hit2, 1);
    @(posedge clk); #1;
    $display("turn2 req=%b hp=%0d/%0d over=%0d winner=%0d", r, hp0_2, hp1_2, game_over2, winner2);
  endtask

  initial begin
    int pulses, n;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("in_reset");
    check("reset_gnt", gnt, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hit", hit, 0);
    check("reset_crit", crit, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed boundary turns
    turn(2'b01, 4'hA, 1'b0);
    turn(2'b01, 4'h7, 1'b0);
    turn(2'b01, 4'h8, 1'b0);
    turn(2'b10, 4'hF, 1'b0);
    do_restart(2'b00);
    repeat (4) turn(2'b11, 4'hC, 1'b1);
    req = 2'b00;

    // Second instance: zero settle, saturating damage
    t2_turn(2'b01, 2'b01);
    check("d2_hp1_a", hp1_2, 1);
    check("d2_hp0_a", hp0_2, 4);
    check("d2_over_a", game_over2, 0);
    t2_turn(2'b01, 2'b01);
    check("d2_hp1_b", hp1_2, 0);
    check("d2_over_b", game_over2, 1);
    check("d2_winner", winner2, 0);
    t2_turn(2'b10, 2'b00);
    check("d2_hp0_c", hp0_2, 4);

    // Random turns until (and beyond) game over
    for (int i = 0; i < 50; i++) begin
      turn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    req = 2'b00;
    n = 0;
    while (!m_over && n < 30) begin
      turn(2'b01, 4'hE, 1'b0);
      n++;
    end
    check("game_over_reached", game_over, 1);
    turn(2'b11, 4'hC, 1'b0);
    turn(2'b10, 4'hF, 1'b0);
    do_restart(2'b11);

    // restart with a pending request is not granted
    do_restart(2'b01);

    // restart in SETTLE aborts the turn
    turn(2'b10, 4'h9, 1'b0);
    req = 2'b01;
    rnd_in = 4'hA;
    @(negedge clk);
    check("gnt_abort", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    do_restart(2'b00);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check_state("abort_idle");

    // async reset in the middle of a turn
    @(posedge clk); #1;
    turn(2'b01, 4'hB, 1'b0);
    req = 2'b01;
    rnd_in = 4'hB;
    @(negedge clk);
    check("gnt_rst", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    #1 reset = 1'b0;
    #1;
    model_reset();
    $display("async reset mid-turn hp=%0d/%0d busy=%0d", hp0, hp1, busy);
    check_state("async_reset");
    check("busy_async_reset", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    turn(2'b10, 4'hF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
